// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB types: broadcast payload, source count and source enumeration.
package rv32i_types;

   localparam int unsigned XLEN        = 32;
   localparam int unsigned ROB_IDX_W   = 6;
   localparam int unsigned CDB_NUM_SRC = 4;

   typedef enum logic [1:0] {
      CDB_ALU = 2'd0,
      CDB_MUL = 2'd1,
      CDB_DIV = 2'd2,
      CDB_MEM = 2'd3
   } cdb_src_e;

   typedef struct packed {
      logic                 cdb_valid;
      logic [ROB_IDX_W-1:0] rob;
      logic [XLEN-1:0]      data;
   } cdb_t;

endpackage

// File: rtl/cdb_src_fifo.sv
// Per-source result queue feeding the CDB arbiter; ready is a pure function of occupancy.
module cdb_src_fifo
   import rv32i_types::*;
#(
   parameter int unsigned QDEPTH = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    push,
   input  logic                    pop,
   input  logic                    flush,
   input  cdb_t                    din,
   output cdb_t                    head,
   output logic [$clog2(QDEPTH):0] count,
   output logic                    ready
);

   localparam int unsigned AW = $clog2(QDEPTH);
   localparam int unsigned CW = AW + 1;

   cdb_t          mem [QDEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic          do_push;
   logic          do_pop;

   // Held low in reset so no producer can hand off a result then.
   assign ready   = rst_n && (count != CW'(QDEPTH));
   assign do_push = push && ready;
   assign do_pop  = pop && (count != '0);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   // Storage needs no reset; only slots below count are ever read.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin common-data-bus arbiter with per-source queues and a registered broadcast.
// Optional CDB_PERF_CNT_EN adds saturating grant_cnt / conflict_cnt outputs.
module cdb_arbiter
   import rv32i_types::*;
#(
   parameter int unsigned NUM_SRC = CDB_NUM_SRC,
   parameter int unsigned QDEPTH  = 2
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         flush,
   input  logic [NUM_SRC-1:0]           req_valid,
   input  cdb_t [NUM_SRC-1:0]           req_data,
   output logic [NUM_SRC-1:0]           req_ready,
   output cdb_t                         cdb,
   output logic [$clog2(NUM_SRC)-1:0]   cdb_src
`ifdef CDB_PERF_CNT_EN
   ,
   output logic [NUM_SRC-1:0][31:0]     grant_cnt,
   output logic [31:0]                  conflict_cnt
`endif
);

   localparam int unsigned SW = $clog2(NUM_SRC);
   localparam int unsigned CW = $clog2(QDEPTH) + 1;

   cdb_t              heads [NUM_SRC];
   logic [CW-1:0]     counts [NUM_SRC];
   logic [NUM_SRC-1:0] nonempty;
   logic [NUM_SRC-1:0] pop;
   logic [SW-1:0]     rr_ptr;
   logic [SW-1:0]     rr_next;
   logic [SW-1:0]     gnt_idx;
   logic              gnt_any;
   cdb_t              gnt_data;
   int unsigned       scan;

   for (genvar i = 0; i < int'(NUM_SRC); i++) begin : g_src
      cdb_src_fifo #(.QDEPTH(QDEPTH)) u_fifo (
         .clk   (clk),
         .rst_n (rst_n),
         .push  (req_valid[i]),
         .pop   (pop[i]),
         .flush (flush),
         .din   (req_data[i]),
         .head  (heads[i]),
         .count (counts[i]),
         .ready (req_ready[i])
      );
      assign nonempty[i] = (counts[i] != '0);
      assign pop[i]      = gnt_any && (gnt_idx == SW'(i));
   end

   // Scan from rr_ptr with an explicit wrap so NUM_SRC need not be a power of two.
   always_comb begin
      gnt_any = 1'b0;
      gnt_idx = '0;
      scan    = 0;
      for (int unsigned k = 0; k < NUM_SRC; k++) begin
         scan = 32'(rr_ptr) + k;
         if (scan >= NUM_SRC) scan = scan - NUM_SRC;
         if (!gnt_any && nonempty[SW'(scan)]) begin
            gnt_any = 1'b1;
            gnt_idx = SW'(scan);
         end
      end
   end

   always_comb begin
      gnt_data           = heads[gnt_idx];
      gnt_data.cdb_valid = 1'b1;
      rr_next            = (gnt_idx == SW'(NUM_SRC - 1)) ? '0 : gnt_idx + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cdb     <= '0;
         cdb_src <= '0;
         rr_ptr  <= '0;
      end else if (flush) begin
         cdb    <= '0;
         rr_ptr <= '0;
      end else if (gnt_any) begin
         cdb     <= gnt_data;
         cdb_src <= gnt_idx;
         rr_ptr  <= rr_next;
      end else begin
         cdb <= '0;
      end
   end

`ifdef CDB_PERF_CNT_EN
   int unsigned ne_cnt;

   always_comb begin
      ne_cnt = 0;
      for (int unsigned k = 0; k < NUM_SRC; k++) ne_cnt = ne_cnt + 32'(nonempty[k]);
   end

   // Flush-cycle grants are discarded, so they are not counted; conflicts still are.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant_cnt    <= '0;
         conflict_cnt <= '0;
      end else begin
         for (int unsigned k = 0; k < NUM_SRC; k++) begin
            if (pop[k] && !flush && (grant_cnt[k] != '1)) grant_cnt[k] <= grant_cnt[k] + 1'b1;
         end
         if ((ne_cnt >= 2) && (conflict_cnt != '1)) conflict_cnt <= conflict_cnt + 1'b1;
      end
   end
`endif

endmodule
